cancel_queue: RTL and testbench
===============================

CANCEL_QUEUE -- requirements
Module: cancel_queue

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DATA_WIDTH, 32, payload width.
  DEPTH, 1024, slot count; power of 2, >= SCAN_SIZE.
  SCAN_SIZE, 16, slots examined per scan cycle; power of 2.
  GEN_WIDTH, 4, per-slot generation tag width.
  PTR_WIDTH, $clog2(DEPTH), derived; HANDLE_WIDTH = PTR_WIDTH+GEN_WIDTH.
REQ-002 Ports (name direction width meaning), one per line:
  clk  in  1  single clock, rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  push_valid  in  1  push request.
  push_ready  out  1  space available; push fires on push_valid&&push_ready.
  push_data  in  DATA_WIDTH  payload.
  push_handle  out  HANDLE_WIDTH  {gen, slot} assigned to the firing push, valid in the fire cycle.
  pop_valid  out  1  head entry live and presentable.
  pop_ready  in  1  consumer accepts; pop fires on pop_valid&&pop_ready.
  pop_data  out  DATA_WIDTH  head payload, 0 when pop_valid=0.
  remove_valid  in  1  cancel request.
  remove_handle  in  HANDLE_WIDTH  entry to cancel.
  remove_ack  out  1  one-cycle pulse, cancel succeeded.
  remove_err  out  1  one-cycle pulse, cancel rejected.
  size  out  PTR_WIDTH+1  live entry count.
  empty  out  1  size==0.
  full  out  1  span (tail-head, PTR_WIDTH+1 bits) ==DEPTH.

Function
REQ-003 Per slot: payload, live bit, generation tag; head/tail pointers wrap modulo DEPTH.
REQ-004 push_ready = !full; on push fire: payload written at tail, live set, slot gen incremented (wraps), push_handle = {incremented gen, tail}, tail+1.
REQ-005 Push while !push_ready SHALL be ignored without state change.
REQ-006 Remove accepted iff handle slot live and slot gen == handle gen and not (pop fires on same slot that cycle); then live cleared, size-1, remove_ack=1 next cycle; otherwise remove_err=1 next cycle, no state change.
REQ-007 Head FSM states: EMPTY (span==0), READY (live[head]), SCAN (span>0, !live[head]); state is registered, recomputed every cycle from next head/tail/live.
REQ-008 pop_valid=1 only in READY; pop_data=mem[head] combinationally in READY.
REQ-009 Pop fire: live[head] cleared, head+1, size-1; no further skip in the same cycle.
REQ-010 In SCAN, each cycle head advances to first live slot among next SCAN_SIZE slots starting at head, else by SCAN_SIZE; advance capped at span.
REQ-011 Gap of G dead slots SHALL cost ceil(G/SCAN_SIZE) SCAN cycles before pop_valid rises.
REQ-012 size next = size + push_fire - pop_fire - remove_accept; push, pop, remove may all fire in one cycle.
REQ-013 Push into a slot still holding stale dead entries beyond head is impossible (tail never passes head+DEPTH); full counts dead-but-unscanned slots.
REQ-014 Push into empty queue: pop_valid rises the cycle after push fire.

Reset
REQ-015 reset_n low asynchronously clears head, tail, size, all live bits, all gen tags, remove_ack, remove_err; state=EMPTY; payload memory not reset.
REQ-016 Outputs during/after reset: push_ready=1, pop_valid=0, pop_data=0, empty=1, full=0, size=0; operations in flight at reset are discarded.

Structure
REQ-017 Package cancel_queue_pkg holds the head-FSM state enum and the handle pack/unpack functions.
REQ-018 Sub-module cancel_queue_scan: combinational SCAN_SIZE-wide priority finder returning offset (0..SCAN_SIZE) of first live slot.

Verification
REQ-019 Reset, push 3 (A,B,C), pop 3 with pop_ready=1 -> pop_data A,B,C in order, size 3->0, empty=1.
REQ-020 Push 40 entries, remove handles of slots 0..33 -> 34 remove_ack pulses; pop_valid low 3 cycles (SCAN_SIZE=16), then pop_data = entry 34.
REQ-021 Remove same handle twice -> remove_ack then remove_err; remove with stale gen after slot reused -> remove_err, live entry untouched.
REQ-022 Fill DEPTH entries -> full=1, push_ready=0; extra push ignored; one pop -> full=0 next cycle; wrap push lands slot 0 with gen 2.
REQ-023 Same cycle push, pop fire and valid remove of another entry -> size unchanged minus 1; remove targeting firing head -> remove_err.
REQ-024 reset_n pulsed low mid-SCAN with size 5 -> immediately size=0, empty=1, pop_valid=0; next push is slot 0 gen 1.

Source files
------------

// File: rtl/cancel_queue_pkg.sv
// Shared types and handle helpers for the cancellable FIFO.
// A handle is {generation, slot}; the generation guards against stale cancels.
package cancel_queue_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_READY,
    ST_SCAN
  } head_state_t;

  localparam int HANDLE_BUS_W = 64;
  typedef logic [HANDLE_BUS_W-1:0] handle_bus_t;

  function automatic handle_bus_t pack_handle(input handle_bus_t gen,
                                              input handle_bus_t slot,
                                              input int          ptr_width);
    return (gen << ptr_width) | slot;
  endfunction

  function automatic handle_bus_t handle_slot(input handle_bus_t handle,
                                              input int          ptr_width);
    return handle & ((handle_bus_t'(1) << ptr_width) - handle_bus_t'(1));
  endfunction

  function automatic handle_bus_t handle_gen(input handle_bus_t handle,
                                             input int          ptr_width);
    return handle >> ptr_width;
  endfunction

endpackage

// File: rtl/cancel_queue_scan.sv
// Priority finder: offset of the first set bit in the window, SCAN_SIZE if none.
module cancel_queue_scan
  import cancel_queue_pkg::*;
#(
  parameter int SCAN_SIZE = 16,
  parameter int OFF_WIDTH = $clog2(SCAN_SIZE) + 1
) (
  input  logic [SCAN_SIZE-1:0] window,
  output logic [OFF_WIDTH-1:0] offset
);

  // NOTE: offset gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    offset = OFF_WIDTH'(SCAN_SIZE);
    for (int i = SCAN_SIZE - 1; i >= 0; i--) begin
      if (window[i]) offset = OFF_WIDTH'(i);
    end
  end

endmodule

// File: rtl/cancel_queue.sv
// FIFO with handle-based cancellation; cancelled slots are skipped by a
// bounded-width scanner at the head instead of being compacted.
module cancel_queue
  import cancel_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int SCAN_SIZE  = 16,
  parameter int GEN_WIDTH  = 4,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push_valid,
  output logic                           push_ready,
  input  logic [DATA_WIDTH-1:0]          push_data,
  output logic [PTR_WIDTH+GEN_WIDTH-1:0] push_handle,
  output logic                           pop_valid,
  input  logic                           pop_ready,
  output logic [DATA_WIDTH-1:0]          pop_data,
  input  logic                           remove_valid,
  input  logic [PTR_WIDTH+GEN_WIDTH-1:0] remove_handle,
  output logic                           remove_ack,
  output logic                           remove_err,
  output logic [PTR_WIDTH:0]             size,
  output logic                           empty,
  output logic                           full
);

  localparam int               HANDLE_WIDTH = PTR_WIDTH + GEN_WIDTH;
  localparam int               OFF_WIDTH    = $clog2(SCAN_SIZE) + 1;
  localparam logic [PTR_WIDTH:0] PTR_ONE    = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0] DEPTH_CNT  = (PTR_WIDTH+1)'(DEPTH);

  logic [PTR_WIDTH:0]                  head_q, tail_q, size_q;
  logic [PTR_WIDTH:0]                  head_d, tail_d, size_d, span, span_d;
  logic [DEPTH-1:0]                    live_q, live_d;
  logic [DEPTH-1:0][GEN_WIDTH-1:0]     gen_q;
  logic [DATA_WIDTH-1:0]               mem [DEPTH];
  head_state_t                         state_q, state_d;

  logic [PTR_WIDTH-1:0]  head_idx, tail_idx, rm_slot;
  logic [GEN_WIDTH-1:0]  rm_gen, push_gen;
  logic                  push_fire, pop_fire, rm_accept;
  logic [SCAN_SIZE-1:0]  scan_window;
  logic [OFF_WIDTH-1:0]  scan_offset;
  logic [PTR_WIDTH:0]    scan_off_ext, scan_adv;

  assign head_idx = head_q[PTR_WIDTH-1:0];
  assign tail_idx = tail_q[PTR_WIDTH-1:0];
  assign span     = tail_q - head_q;

  assign full       = (span == DEPTH_CNT);
  assign push_ready = !full;
  assign push_fire  = push_valid && push_ready;
  assign push_gen   = gen_q[tail_idx] + GEN_WIDTH'(1);
  assign push_handle = HANDLE_WIDTH'(pack_handle(handle_bus_t'(push_gen),
                                                 handle_bus_t'(tail_idx), PTR_WIDTH));

  assign pop_valid = (state_q == ST_READY);
  assign pop_fire  = pop_valid && pop_ready;
  assign pop_data  = pop_valid ? mem[head_idx] : '0;

  assign rm_slot = PTR_WIDTH'(handle_slot(handle_bus_t'(remove_handle), PTR_WIDTH));
  assign rm_gen  = GEN_WIDTH'(handle_gen(handle_bus_t'(remove_handle), PTR_WIDTH));
  // A cancel racing the pop of the same head entry loses: the consumer already has it.
  assign rm_accept = remove_valid && live_q[rm_slot] && (gen_q[rm_slot] == rm_gen) &&
                     !(pop_fire && (rm_slot == head_idx));

  assign size  = size_q;
  assign empty = (size_q == '0);

  for (genvar i = 0; i < SCAN_SIZE; i++) begin : g_window
    assign scan_window[i] = live_q[head_idx + PTR_WIDTH'(i)];
  end

  cancel_queue_scan #(
    .SCAN_SIZE (SCAN_SIZE),
    .OFF_WIDTH (OFF_WIDTH)
  ) u_scan (
    .window (scan_window),
    .offset (scan_offset)
  );

  // Never skip past the tail, even when the whole window is dead.
  assign scan_off_ext = (PTR_WIDTH+1)'(scan_offset);
  assign scan_adv     = (scan_off_ext > span) ? span : scan_off_ext;

  assign size_d = size_q + (PTR_WIDTH+1)'(push_fire)
                         - (PTR_WIDTH+1)'(pop_fire)
                         - (PTR_WIDTH+1)'(rm_accept);

  always_comb begin
    live_d  = live_q;
    head_d  = head_q;
    tail_d  = tail_q;
    state_d = ST_EMPTY;
    if (push_fire) begin
      live_d[tail_idx] = 1'b1;
      tail_d           = tail_q + PTR_ONE;
    end
    if (rm_accept) live_d[rm_slot] = 1'b0;
    if (pop_fire) begin
      live_d[head_idx] = 1'b0;
      head_d           = head_q + PTR_ONE;
    end else if (state_q == ST_SCAN) begin
      head_d = head_q + scan_adv;
    end
    span_d = tail_d - head_d;
    if (span_d == '0)                        state_d = ST_EMPTY;
    else if (live_d[head_d[PTR_WIDTH-1:0]])  state_d = ST_READY;
    else                                     state_d = ST_SCAN;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      size_q     <= '0;
      live_q     <= '0;
      gen_q      <= '0;
      state_q    <= ST_EMPTY;
      remove_ack <= 1'b0;
      remove_err <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      size_q     <= size_d;
      live_q     <= live_d;
      state_q    <= state_d;
      remove_ack <= rm_accept;
      remove_err <= remove_valid && !rm_accept;
      if (push_fire) gen_q[tail_idx] <= push_gen;
    end
  end

  // NOTE: payload storage is left unreset; the live bits alone decide what is visible.
  always_ff @(posedge clk) begin
    if (push_fire) mem[tail_idx] <= push_data;
  end

endmodule

// File: tb/tb_cancel_queue.sv
// Scoreboard bench: the driver keeps an ordered list of live entries; the monitor
// checks pops, cancel responses and size against it every cycle.
module tb_cancel_queue;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 1024;
  localparam int SCAN_SIZE  = 16;
  localparam int GEN_WIDTH  = 4;
  localparam int PTR_WIDTH  = $clog2(DEPTH);
  localparam int HW         = PTR_WIDTH + GEN_WIDTH;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  push_valid = 1'b0, pop_ready = 1'b0, remove_valid = 1'b0;
  logic [DATA_WIDTH-1:0] push_data = '0;
  logic [HW-1:0]         remove_handle = '0;
  logic                  push_ready, pop_valid, remove_ack, remove_err, empty, full;
  logic [HW-1:0]         push_handle;
  logic [DATA_WIDTH-1:0] pop_data;
  logic [PTR_WIDTH:0]    size;

  cancel_queue #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .SCAN_SIZE  (SCAN_SIZE),
    .GEN_WIDTH  (GEN_WIDTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .push_data     (push_data),
    .push_handle   (push_handle),
    .pop_valid     (pop_valid),
    .pop_ready     (pop_ready),
    .pop_data      (pop_data),
    .remove_valid  (remove_valid),
    .remove_handle (remove_handle),
    .remove_ack    (remove_ack),
    .remove_err    (remove_err),
    .size          (size),
    .empty         (empty),
    .full          (full)
  );

  always #5 clk = ~clk;

  typedef struct { logic [HW-1:0] handle; logic [DATA_WIDTH-1:0] data; } entry_t;
  typedef struct { int cyc; bit accept; } rm_exp_t;

  entry_t        sb[$];
  logic [HW-1:0] retired[$];
  rm_exp_t       rm_exp[$];
  int            model_gen [DEPTH];
  int            pushes, pop_count, ack_count;
  int            vectors, miscompares;
  int            cyc = 0;
  bit            mon_en = 1'b0;
  entry_t        mon_e;
  rm_exp_t       mon_r;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [HW-1:0] mk_h(input int g, input int s);
    return {GEN_WIDTH'(g), PTR_WIDTH'(s)};
  endfunction

  task automatic model_reset();
    sb.delete();
    retired.delete();
    rm_exp.delete();
    foreach (model_gen[i]) model_gen[i] = 0;
    pushes    = 0;
    pop_count = 0;
  endtask

  // One clock of stimulus; the model decides what fires from the handshakes.
  task automatic step(input bit pv, input logic [DATA_WIDTH-1:0] pd, input bit prdy,
                      input bit rv, input logic [HW-1:0] rh);
    bit            pop_fire, accept;
    int            idx, slot;
    logic [HW-1:0] exp_h;
    @(negedge clk);
    push_valid = pv; push_data = pd; pop_ready = prdy;
    remove_valid = rv; remove_handle = rh;
    #2;
    pop_fire = pop_valid && pop_ready;
    if (rv) begin
      idx = -1;
      foreach (sb[i]) if (sb[i].handle == rh) idx = i;
      accept = (idx >= 0) && !(pop_fire && idx == 0);
      if (accept) begin
        retired.push_back(rh);
        sb.delete(idx);
      end
      rm_exp.push_back('{cyc, accept});
    end
    if (pv && push_ready) begin
      slot = pushes % DEPTH;
      model_gen[slot] = (model_gen[slot] + 1) % (1 << GEN_WIDTH);
      exp_h = mk_h(model_gen[slot], slot);
      check("push_handle", push_handle, exp_h);
      sb.push_back('{exp_h, pd});
      pushes++;
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset_n = 1'b0;
    model_reset();
    push_valid = 0; pop_ready = 0; remove_valid = 0;
    #1;
    check("rst_size", size, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_push_ready", push_ready, 1);
    check("rst_pop_valid", pop_valid, 0);
    check("rst_pop_data", pop_data, 0);
    @(negedge clk); #3;
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step(0, '0, 1, 0, '0);
      n++;
    end
    check("drain_remaining", sb.size(), 0);
    step(0, '0, 0, 0, '0);
  endtask

  // Monitor: state checks early in the low phase, handshake results later.
  initial forever begin
    @(negedge clk); #1;
    if (mon_en) begin
      check("size", size, sb.size());
      check("empty", empty, sb.size() == 0);
      check("pop_valid_without_entry", pop_valid && sb.size() == 0, 0);
    end
    #3;
    if (mon_en) begin
      if (pop_valid && pop_ready) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL pop_underflow: got pop of %0h expected no pop", pop_data);
        end else begin
          mon_e = sb.pop_front();
          check("pop_data", pop_data, mon_e.data);
          retired.push_back(mon_e.handle);
          pop_count++;
        end
      end
      if (!pop_valid) check("pop_data_idle", pop_data, 0);
      if (rm_exp.size() != 0 && rm_exp[0].cyc == cyc - 1) begin
        mon_r = rm_exp.pop_front();
        check("remove_ack", remove_ack, mon_r.accept);
        check("remove_err", remove_err, !mon_r.accept);
      end else begin
        check("remove_spurious", {remove_ack, remove_err}, 0);
      end
      if (remove_ack) ack_count++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_WIDTH-1:0] gap_data [40];
    logic [HW-1:0]         rh;
    int                    low, ack0, pick;
    bit                    pv;

    #2 do_reset();

    // In-order push/pop of three, plus push-to-pop latency.
    step(1, 32'h0000_00A1, 0, 0, '0);
    check("latency_before_edge", pop_valid, 0);
    step(1, 32'h0000_00B2, 0, 0, '0);
    check("latency_after_push", pop_valid, 1);
    step(1, 32'h0000_00C3, 0, 0, '0);
    step(0, '0, 0, 0, '0);
    check("abc_size", size, 3);
    drain(10);
    check("abc_empty", empty, 1);

    // Cancel a 34-slot prefix (tail end first so the head waits), then time the skip.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      gap_data[i] = $urandom;
      step(1, gap_data[i], 0, 0, '0);
    end
    ack0 = ack_count;
    for (int i = 33; i >= 0; i--) step(0, '0, 0, 1, mk_h(1, i));
    low = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, '0, 0, 0, '0);
      if (pop_valid) break;
      low++;
    end
    check("gap_ack_count", ack_count - ack0, 34);
    check("gap_scan_cycles", low, 3);
    check("gap_head_data", pop_data, gap_data[34]);
    drain(20);

    // Double cancel.
    do_reset();
    step(1, 32'h1111_1111, 0, 0, '0);
    step(1, 32'h2222_2222, 0, 0, '0);
    step(0, '0, 0, 1, mk_h(1, 0));
    step(0, '0, 0, 1, mk_h(1, 0));
    check("cancel_first_ack", remove_ack, 1);
    step(0, '0, 0, 0, '0);
    check("cancel_second_err", remove_err, 1);
    drain(20);

    // Fill, overflow attempt, wrap push and a stale-generation cancel.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, $urandom, 0, 0, '0);
    step(0, '0, 0, 0, '0);
    check("fill_full", full, 1);
    check("fill_push_ready", push_ready, 0);
    check("fill_size", size, DEPTH);
    step(1, 32'hDEAD_BEEF, 0, 0, '0);
    step(0, '0, 1, 0, '0);
    check("fill_overflow_size", size, DEPTH);
    step(0, '0, 0, 0, '0);
    check("after_pop_full", full, 0);
    check("after_pop_push_ready", push_ready, 1);
    step(1, 32'h1234_5678, 0, 0, '0);
    check("wrap_handle", push_handle, mk_h(2, 0));
    step(0, '0, 0, 1, mk_h(1, 0));
    step(0, '0, 0, 0, '0);
    check("stale_cancel_err", remove_err, 1);
    check("stale_cancel_size", size, DEPTH);
    drain(DEPTH + 50);

    // Push, pop and cancel in one cycle; cancel racing the head pop.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 32'hC000_0000 + i, 0, 0, '0);
    step(0, '0, 0, 0, '0);
    step(0, '0, 1, 1, mk_h(1, 0));
    step(1, 32'hD000_000D, 1, 1, mk_h(1, 2));
    check("race_head_err", remove_err, 1);
    check("triple_size_before", size, 2);
    step(0, '0, 0, 0, '0);
    check("triple_size_after", size, 1);
    drain(20);

    // Asynchronous reset while the head is scanning.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, $urandom, 0, 0, '0);
    for (int i = 4; i >= 0; i--) step(0, '0, 0, 1, mk_h(1, i));
    @(posedge clk); #2;
    check("scan_pop_valid", pop_valid, 0);
    check("scan_size", size, 5);
    do_reset();
    step(1, 32'h5555_AAAA, 0, 0, '0);
    check("post_reset_handle", push_handle, mk_h(1, 0));
    drain(20);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      pv = ($urandom_range(0, 99) < 55) && ((pushes - pop_count) < 200);
      pick = $urandom_range(0, 2);
      if (pick == 0 && sb.size() != 0)           rh = sb[$urandom_range(0, sb.size() - 1)].handle;
      else if (pick == 1 && retired.size() != 0) rh = retired[$urandom_range(0, retired.size() - 1)];
      else                                        rh = HW'($urandom);
      step(pv, $urandom, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 30, rh);
      if (pv) check("random_push_ready", push_ready, 1);
    end
    drain(2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
